imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the byte-array instruction memory.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles bytes into 32-bit big-endian instruction words: first byte received goes to [31:24], so it lands at mem[addr+0].
- Issues single-cycle word writes to the memory's write port, and holds the core (busy) while loading.

Parameters:
- MEM_SIZE, 4095: instruction memory capacity in bytes. Images larger than this are rejected.
- BASE_ADDR, 64'h0: byte address of the first written word.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse; begins a load. Ignored while busy.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  64  byte address of the word; always 4-aligned.
- wr_data  output  32  big-endian word; [31:24] goes to wr_addr+0.
- busy  output  1  load in progress; core must be held.
- done  output  1  sticky; last load finished.
- error  output  1  sticky; last load rejected because length exceeded MEM_SIZE.
- words_written  output  32  count of wr_en pulses in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - in_ready, wr_en, busy, done, error = 0.
  - wr_addr, wr_data, words_written, internal length/byte counters = 0.
  - Reset mid-load aborts immediately; no further wr_en.
- State machine: IDLE, HDR, DATA, DONE.
- IDLE: in_ready=0. start=1 goes to HDR; clears the length register, byte counter, words_written, done and error; busy=1 from the next cycle.
- HDR: in_ready=1. Accepts exactly 4 bytes, shifted MSB-first into 32-bit LEN (the first byte becomes LEN[31:24]). On the 4th transfer:
  - LEN==0 goes to DONE; done=1, error=0, no writes.
  - LEN>MEM_SIZE goes to DONE; done=1, error=1, no writes.
  - Otherwise goes to DATA.
- DATA: in_ready=1.
  - Each transfer places the byte into word-buffer lane (3 - k), where k = byte index within the word (0..3); the buffer is cleared at the start of each word.
  - A word is complete on the 4th byte of the word, or on the transfer of byte LEN-1, whichever comes first.
  - Write timing: wr_en=1 for exactly the cycle after the completing transfer, with:
    - wr_data = buffer; unfilled low lanes are 8'h00.
    - wr_addr = BASE_ADDR + 4*word_index.
    - words_written increments in that same cycle.
  - Transfers continue back-to-back while the write is pending; the memory is assumed always able to accept a write.
  - After the transfer of byte LEN-1, the state goes to DONE. The final wr_en pulse occurs in the first DONE cycle.
- DONE: in_ready=0, busy=0, done=1. start restarts the load (goes to HDR, clears done/error/words_written).
- busy=1 in HDR and DATA, and for the final write cycle; otherwise busy=0.
- Handshake:
  - in_valid low in HDR/DATA stalls the load; no timeout.
  - Bytes offered while in_ready=0 are not consumed.
- start asserted in HDR or DATA is ignored.
- Address arithmetic is 64-bit and unsigned. The byte counter is 32-bit; LEN ≤ MEM_SIZE guarantees no wrap.
- Latency: wr_en asserts 1 cycle after the completing byte handshake. done asserts 1 cycle after the final handshake.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0, in_ready=0. Release → still IDLE, no wr_en.
- Full words: start; header 00 00 00 08; data 00 50 00 93 00 00 00 73 (in_valid constantly 1).
  - Writes: 0x00500093@0, then 0x00000073@4.
  - Each write 1 cycle after its 4th byte.
  - Final state: words_written=2, done=1, error=0, busy=0.
- Partial tail: LEN=6, data AA BB CC DD EE FF → writes 0xAABBCCDD@0 and 0xEEFF0000@4; done=1.
- Boundary lengths:
  - LEN=0 → done=1, error=0, zero writes.
  - LEN=0x00001388 (5000) → done=1, error=1, zero writes, in_ready=0 after the header.
  - LEN=4095 accepted → 1024 writes; last write 0xXXXXXX00 at addr 4092.
- Stalls and abort:
  - Random in_valid bubbles during the full-words case → identical writes.
  - Assert reset after 2 data bytes → wr_en never pulses, state returns to IDLE. A fresh load then succeeds.
- start handling: start pulses during DATA are ignored (same result as the full-words case). start in DONE clears done/error and reloads at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 4-byte big-endian length header followed by
// the image bytes, and emits big-endian 32-bit word writes to the instruction memory.
module imem_loader #(
  parameter int unsigned MEM_SIZE  = 4095,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] len_reg, len_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] buf_reg, buf_next;
  logic        wr_en_reg, wr_en_next;
  logic [63:0] wr_addr_reg, wr_addr_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic [31:0] words_reg, words_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;

  logic        xfer;
  logic [1:0]  lane_idx;
  logic [31:0] merged_word;
  logic [31:0] hdr_len;
  logic        last_byte;

  // lane_idx = 3 - k; lanes other than the one being filled keep the buffer,
  // except on the first byte of a word where they are cleared.
  assign lane_idx = ~cnt_reg[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = (lane_idx == 2'(gi)) ? in_byte :
                                      (cnt_reg[1:0] == 2'd0) ? 8'h00 : buf_reg[8*gi +: 8];
    end
  endgenerate

  assign in_ready  = (state_reg == HDR) || (state_reg == DATA);
  assign xfer      = in_valid && in_ready;
  assign hdr_len   = {len_reg[23:0], in_byte};
  assign last_byte = (cnt_reg == len_reg - 32'd1);

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    cnt_next     = cnt_reg;
    buf_next     = buf_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    words_next   = words_reg;
    done_next    = done_reg;
    error_next   = error_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = HDR;
          len_next   = 32'd0;
          cnt_next   = 32'd0;
          words_next = 32'd0;
          done_next  = 1'b0;
          error_next = 1'b0;
        end
      end
      HDR: begin
        if (xfer) begin
          len_next = hdr_len;
          cnt_next = cnt_reg + 32'd1;
          if (cnt_reg[1:0] == 2'd3) begin
            cnt_next = 32'd0;
            if (hdr_len == 32'd0) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else if (hdr_len > MEM_SIZE) begin
              state_next = DONE;
              done_next  = 1'b1;
              error_next = 1'b1;
            end else begin
              state_next = DATA;
            end
          end
        end
      end
      DATA: begin
        if (xfer) begin
          buf_next = merged_word;
          cnt_next = cnt_reg + 32'd1;
          if (cnt_reg[1:0] == 2'd3 || last_byte) begin
            wr_en_next   = 1'b1;
            wr_addr_next = BASE_ADDR + {words_reg[29:0], 2'b00} + {32'd0, words_reg[31:30] & 2'b00, 30'd0};
            wr_data_next = merged_word;
            words_next   = words_reg + 32'd1;
          end
          if (last_byte) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      len_reg     <= 32'd0;
      cnt_reg     <= 32'd0;
      buf_reg     <= 32'd0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 64'd0;
      wr_data_reg <= 32'd0;
      words_reg   <= 32'd0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      cnt_reg     <= cnt_next;
      buf_reg     <= buf_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      words_reg   <= words_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  // The final word's write lands in the first DONE cycle, so busy covers it.
  assign busy          = in_ready || wr_en_reg;
  assign wr_en         = wr_en_reg;
  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign words_written = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the load driver pushes expected writes,
// a negedge monitor pops and compares them against every wr_en pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, busy, done, error;
  logic [63:0] wr_addr;
  logic [31:0] wr_data, words_written;

  imem_loader #(.MEM_SIZE(4095), .BASE_ADDR(64'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          wcyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("write addr=%0h data=%08h cycle=%0d", wr_addr, wr_data, cyc);
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
        check("wr_cycle", 64'(cyc), 64'(e.wcyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bubbles, input bit noise, output int xcyc);
    int t;
    @(negedge clk);
    if (bubbles) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("in_ready_timeout", 64'd0, 64'd1);
      xcyc = -1;
      in_valid = 1'b0;
      return;
    end
    if (noise) start = 1'($urandom_range(0, 1));
    xcyc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("done_cleared", {63'd0, done}, 64'd0);
    check("error_cleared", {63'd0, error}, 64'd0);
    check("words_cleared", {32'd0, words_written}, 64'd0);
  endtask

  task automatic send_header(input logic [31:0] len);
    int xc;
    for (int i = 0; i < 4; i++) send_byte(len[31-8*i -: 8], 1'b0, 1'b0, xc);
  endtask

  task automatic run_load(input logic [31:0] len, input logic [7:0] data[$],
                          input bit bubbles, input bit noise, input bit exp_err);
    int          xc;
    int          nw;
    int          n;
    logic [31:0] w;
    pulse_start();
    send_header(len);
    nw = 0;
    w  = 32'd0;
    n  = (len == 0 || exp_err) ? 0 : int'(len);
    for (int i = 0; i < n; i++) begin
      send_byte(data[i], bubbles, noise, xc);
      if (i % 4 == 0) w = 32'd0;
      w[8*(3 - i % 4) +: 8] = data[i];
      if (i % 4 == 3 || i == n - 1) begin
        exp_q.push_back('{addr: 64'(nw) * 64'd4, data: w, wcyc: xc});
        nw++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    check("in_ready_after_load", {63'd0, in_ready}, 64'd0);
    check("done", {63'd0, done}, 64'd1);
    check("error", {63'd0, error}, {63'd0, exp_err});
    repeat (2) @(negedge clk);
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("done_hold", {63'd0, done}, 64'd1);
    check("words_written", {32'd0, words_written}, 64'(nw));
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("load len=%0d words=%0d done=%0b error=%0b", len, words_written, done, error);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
    check({tag, "_wr_addr"}, wr_addr, 64'd0);
    check({tag, "_wr_data"}, {32'd0, wr_data}, 64'd0);
    check({tag, "_words"}, {32'd0, words_written}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] full_data[$];
    logic [7:0] tail_data[$];
    logic [7:0] big_data[$];
    logic [7:0] none[$];
    int         xc;

    full_data = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h73};
    tail_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    for (int i = 0; i < 4095; i++) big_data.push_back(8'(i));

    // Reset held with random inputs.
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_byte  = 8'($urandom_range(0, 255));
      #1;
      check_reset_outputs("reset");
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_reset");

    // Full words: 0x00500093@0, 0x00000073@4.
    run_load(32'd8, full_data, 1'b0, 1'b0, 1'b0);
    // Partial tail: 0xAABBCCDD@0, 0xEEFF0000@4.
    run_load(32'd6, tail_data, 1'b0, 1'b0, 1'b0);
    run_load(32'd0, none, 1'b0, 1'b0, 1'b0);
    run_load(32'h0000_1388, none, 1'b0, 1'b0, 1'b1);
    run_load(32'd8, full_data, 1'b1, 1'b0, 1'b0);
    run_load(32'd8, full_data, 1'b0, 1'b1, 1'b0);
    // Largest accepted image; last write 0xFCFDFE00 at 4092.
    run_load(32'd4095, big_data, 1'b0, 1'b0, 1'b0);

    // Abort after two data bytes.
    pulse_start();
    send_header(32'd8);
    send_byte(8'h00, 1'b0, 1'b0, xc);
    send_byte(8'h50, 1'b0, 1'b0, xc);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_abort");
    $display("abort load checked");
    run_load(32'd8, full_data, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
